// File: rtl/mul_share_sched.sv
// mul_share_sched
// Sequencer and round-robin arbiter that shares one repeated-addition
// multiplier datapath between NREQ requesters. One operand pair is accepted
// at a time. The block drives the datapath strobes and returns the product,
// tagged with the owner's ID, over a valid/ready response channel.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester request handshake (ready is one-hot or zero)
//   req_a, req_b         packed operands, slice i belongs to requester i
//   rsp_valid/rsp_ready  response handshake
//   rsp_data, rsp_id     product (passed through from dp_p) and owner ID
//   dp_data              operand bus to the datapath
//   ldA ldB ldP clrP decB datapath strobes
//   eqz, dp_p            datapath B==0 flag and P register
//   busy                 high whenever the sequencer is not idle
//
// state  | meaning
// IDLE   | arbitrate; grant and latch operands of the round-robin winner
// LOAD_A | drive a_reg onto dp_data, load A
// LOAD_B | drive b_reg onto dp_data, load B, clear P
// ACCUM  | P += A, B -= 1 until eqz
// RESP   | present product until rsp_ready
module mul_share_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      dp_data,
    output logic                  ldA,
    output logic                  ldB,
    output logic                  ldP,
    output logic                  clrP,
    output logic                  decB,
    input  logic                  eqz,
    input  logic [WIDTH-1:0]      dp_p,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ACCUM  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   last_id;
    logic [IDW-1:0]   win_id;
    logic             win_found;
    int               idx;

    // Search starts just after the last served requester and wraps, so the
    // most recently served one has the lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(last_id) + 1 + k) % NREQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            gnt_id  <= '0;
            last_id <= IDW'(NREQ - 1);
        end else begin
            if (state == IDLE && win_found) begin
                a_reg  <= req_a[int'(win_id)*WIDTH +: WIDTH];
                b_reg  <= req_b[int'(win_id)*WIDTH +: WIDTH];
                gnt_id <= win_id;
            end
            if (state == RESP && rsp_ready) begin
                last_id <= gnt_id;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = LOAD_A;
            LOAD_A:  state_nxt = LOAD_B;
            LOAD_B:  state_nxt = ACCUM;
            ACCUM:   if (eqz) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_id    = '0;
        dp_data   = '0;
        ldA       = 1'b0;
        ldB       = 1'b0;
        ldP       = 1'b0;
        clrP      = 1'b0;
        decB      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (win_found) req_ready[win_id] = 1'b1;
            end
            LOAD_A: begin
                dp_data = a_reg;
                ldA     = 1'b1;
            end
            LOAD_B: begin
                dp_data = b_reg;
                ldB     = 1'b1;
                clrP    = 1'b1;
            end
            ACCUM: begin
                // The eqz cycle itself adds nothing: b additions over b+1 cycles.
                ldP  = !eqz;
                decB = !eqz;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = dp_p;
                rsp_id    = gnt_id;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mul_share_sched.sv
module tb_mul_share_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      dp_data;
    logic                  ldA, ldB, ldP, clrP, decB;
    logic                  eqz;
    logic [WIDTH-1:0]      dp_p;
    logic                  busy;

    logic [WIDTH-1:0] dp_ra = '0;
    logic [WIDTH-1:0] dp_rb = '0;
    logic [WIDTH-1:0] dp_rp = '0;

    int n_tests = 0;
    int n_fail  = 0;

    mul_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .dp_data   (dp_data),
        .ldA       (ldA),
        .ldB       (ldB),
        .ldP       (ldP),
        .clrP      (clrP),
        .decB      (decB),
        .eqz       (eqz),
        .dp_p      (dp_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Shared repeated-addition datapath
    always @(posedge clk) begin
        if (ldA) dp_ra <= dp_data;
        if (ldB) dp_rb <= dp_data;
        else if (decB) dp_rb <= dp_rb - 16'd1;
        if (clrP) dp_rp <= '0;
        else if (ldP) dp_rp <= dp_rp + dp_ra;
    end
    assign eqz  = (dp_rb == '0);
    assign dp_p = dp_rp;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int id, input logic [15:0] a, input logic [15:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 100);
        if (!rsp_valid) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Single request from the idle state; starts and ends at a negedge.
    task automatic do_req(input string tag, input int id, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_p);
        int cyc, nacc, nclr, nexcl;
        set_ops(id, a, b);
        req_valid[id] = 1'b1;
        #1;
        check_val({tag, "_rdy"}, 32'(req_ready), 32'(1) << id);
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
        cyc = 0; nacc = 0; nclr = 0; nexcl = 0;
        while (cyc < 300) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (ldP && decB) nacc++;
            if (clrP) nclr++;
            if (int'(ldA) + int'(ldB) + int'(ldP) > 1) nexcl++;
            @(posedge clk);
            cyc++;
        end
        check_val({tag, "_lat"}, 32'(cyc + 1), 32'(4 + int'(b)));
        check_val({tag, "_data"}, 32'(rsp_data), 32'(exp_p));
        check_val({tag, "_id"}, 32'(rsp_id), 32'(id));
        check_val({tag, "_nacc"}, 32'(nacc), 32'(b));
        check_val({tag, "_nclr"}, 32'(nclr), 32'd1);
        check_val({tag, "_excl"}, 32'(nexcl), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_val({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Serve whichever grant comes next among already-valid requesters.
    task automatic serve(input string tag, input int exp_id, input logic [15:0] exp_p,
                         input bit drop);
        int n;
        #1;
        n = 0;
        while (req_ready == '0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val({tag, "_gnt"}, 32'(req_ready), 32'(1) << exp_id);
        @(posedge clk);
        #1 if (drop) req_valid[exp_id] = 1'b0;
        wait_rsp(tag);
        check_val({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        check_val({tag, "_data"}, 32'(rsp_data), 32'(exp_p));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_rvalid", 32'(rsp_valid), 32'd0);
        check_val("rst_strobes", 32'({ldA, ldB, ldP, clrP, decB}), 32'd0);
        check_val("rst_dp_data", 32'(dp_data), 32'd0);
        check_val("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        do_reset();

        do_req("single", 0, 16'd3, 16'd5, 16'd15);
        do_req("zero_b", 2, 16'd7, 16'd0, 16'd0);
        do_req("wrap", 1, 16'h8000, 16'd3, 16'h8000);

        // Round robin, all four valid from reset
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 16'(i + 2), 16'd1);
        req_valid = 4'b1111;
        serve("rr0", 0, 16'd2, 1'b1);
        serve("rr1", 1, 16'd3, 1'b1);
        serve("rr2", 2, 16'd4, 1'b1);
        serve("rr3", 3, 16'd5, 1'b1);
        set_ops(1, 16'd6, 16'd1);
        set_ops(3, 16'd9, 16'd1);
        req_valid = 4'b1010;
        serve("rr4", 1, 16'd6, 1'b0);
        serve("rr5", 3, 16'd9, 1'b1);
        serve("rr6", 1, 16'd6, 1'b1);

        // Backpressure with a second requester pending
        do_reset();
        rsp_ready = 1'b0;
        set_ops(0, 16'd4, 16'd2);
        set_ops(1, 16'd5, 16'd3);
        req_valid = 4'b0011;
        #1;
        check_val("bp_gnt0", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_rsp("bp");
        for (int i = 0; i < 10; i++) begin
            check_val("bp_valid", 32'(rsp_valid), 32'd1);
            check_val("bp_data", 32'(rsp_data), 32'd8);
            check_val("bp_id", 32'(rsp_id), 32'd0);
            check_val("bp_noready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        serve("bp_next", 1, 16'd15, 1'b1);

        // Reset during ACCUM, then check the pointer went back to NREQ-1
        do_reset();
        do_req("pre", 0, 16'd5, 16'd1, 16'd5);
        set_ops(2, 16'd2, 16'd10);
        req_valid[2] = 1'b1;
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_val("mid_busy", 32'(busy), 32'd1);
        check_val("mid_ldp", 32'(ldP), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_strobes", 32'({ldA, ldB, ldP, clrP, decB}), 32'd0);
        check_val("mid_rst_dp_data", 32'(dp_data), 32'd0);
        check_val("mid_rst_rvalid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_ops(0, 16'd2, 16'd10);
        set_ops(1, 16'd3, 16'd1);
        req_valid = 4'b0011;
        #1;
        check_val("post_ptr", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp("post");
        check_val("post_data", 32'(rsp_data), 32'd20);
        check_val("post_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
